// File: rtl/inst_prefetch_unit.sv
`default_nettype none
// ============================================================================
// inst_prefetch_unit : decoupled RV32 fetch front end with a DEPTH-entry buffer
// Rev 1.0
// ============================================================================
module inst_prefetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] PC,
  output logic        Inst_Req_Valid,
  input  logic        Inst_Req_Ready,
  input  logic [31:0] Instruction,
  input  logic        Inst_Valid,
  output logic        Inst_Ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [31:0] fetch_cnt,
  output logic [31:0] drop_cnt
);

  localparam int          CW    = $clog2(DEPTH) + 1;
  localparam int          PW    = $clog2(DEPTH);
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  logic          rst_q;
  logic [31:0]   resp_pc;
  logic [CW-1:0] occupancy;
  logic [CW-1:0] inflight;
  logic [CW-1:0] pending_drop;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];

  logic          req_fire;
  logic          resp_accept;
  logic          resp_drop;
  logic          push;
  logic          pop;
  logic [31:0]   new_pc;

  // Credit rule: a request is only issued if its response is guaranteed a slot.
  assign Inst_Req_Valid = !rst && !rst_q && !redirect_valid &&
                          (({1'b0, occupancy} + {1'b0, inflight}) < LIMIT);
  assign Inst_Ready     = 1'b1;
  assign req_fire       = Inst_Req_Valid && Inst_Req_Ready;

  // Responses with nothing outstanding (e.g. stragglers after reset) are ignored.
  assign resp_accept = Inst_Valid && (inflight != '0);
  assign resp_drop   = resp_accept && (redirect_valid || (pending_drop != '0));
  assign push        = resp_accept && !resp_drop;

  assign out_valid = (occupancy != '0) && !redirect_valid;
  assign pop       = out_valid && out_ready;
  assign out_inst  = inst_mem[head];
  assign out_pc    = pc_mem[head];
  assign new_pc    = redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_q        <= 1'b1;
      PC           <= RESET_PC;
      resp_pc      <= RESET_PC;
      occupancy    <= '0;
      inflight     <= '0;
      pending_drop <= '0;
      head         <= '0;
      tail         <= '0;
      fetch_cnt    <= '0;
      drop_cnt     <= '0;
    end else begin
      rst_q    <= 1'b0;
      inflight <= inflight + CW'(req_fire) - CW'(resp_accept);
      if (req_fire) begin
        PC        <= PC + 32'd4;
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (resp_drop) begin
        drop_cnt <= drop_cnt + 32'd1;
      end
      if (redirect_valid) begin
        // Everything still outstanding after this cycle belongs to the old path.
        occupancy    <= '0;
        head         <= tail;
        PC           <= new_pc;
        resp_pc      <= new_pc;
        pending_drop <= inflight - CW'(resp_accept);
      end else begin
        occupancy <= occupancy + CW'(push) - CW'(pop);
        if (resp_drop) begin
          pending_drop <= pending_drop - CW'(1);
        end
        if (push) begin
          tail    <= tail + PW'(1);
          resp_pc <= resp_pc + 32'd4;
        end
        if (pop) begin
          head <= head + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      inst_mem[tail] <= Instruction;
      pc_mem[tail]   <= resp_pc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_prefetch_unit.sv
`default_nettype none
// Scoreboard bench for inst_prefetch_unit: directed fetch, backpressure, redirect and reset cases.
module tb_inst_prefetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] PC;
  logic        Inst_Req_Valid;
  logic        Inst_Req_Ready = 1'b0;
  logic [31:0] Instruction = '0;
  logic        Inst_Valid = 1'b0;
  logic        Inst_Ready;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] fetch_cnt;
  logic [31:0] drop_cnt;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] sb [$];
  logic [31:0] req_q [$];
  int          grants = 0;
  bit          resp_en = 1'b1;
  bit          inject = 1'b0;

  inst_prefetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .PC(PC), .Inst_Req_Valid(Inst_Req_Valid),
    .Inst_Req_Ready(Inst_Req_Ready), .Instruction(Instruction), .Inst_Valid(Inst_Valid),
    .Inst_Ready(Inst_Ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .fetch_cnt(fetch_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return 32'hA000_0000 + a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_pc(input logic [31:0] a);
    sb.push_back({inst_of(a), a});
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Memory model: one-cycle response latency, request grants rationed by the stimulus.
  initial begin
    logic        hs;
    logic [31:0] hs_pc;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      hs    = Inst_Req_Valid && Inst_Req_Ready;
      hs_pc = PC;
      @(posedge clk);
      #1;
      if (rst) begin
        req_q.delete();
        Inst_Valid = 1'b0;
      end else begin
        if (hs) begin
          req_q.push_back(hs_pc);
          if (grants > 0) grants--;
        end
        if (inject) begin
          Inst_Valid  = 1'b1;
          Instruction = 32'hBAD0_BAD0;
          inject      = 1'b0;
        end else if (resp_en && req_q.size() > 0) begin
          a           = req_q.pop_front();
          Inst_Valid  = 1'b1;
          Instruction = inst_of(a);
        end else begin
          Inst_Valid = 1'b0;
        end
      end
      Inst_Req_Ready = (grants > 0);
    end
  end

  // Monitor: every consumed head entry must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pop: got pc %h inst %h expected nothing", out_pc, out_inst);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        check("out_pc", out_pc, e[31:0]);
        check("out_inst", out_inst, e[63:32]);
      end
    end
  end

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    grants         = 0;
    resp_en        = 1'b1;
    repeat (3) tick();
    sb.delete();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values and sequential fetch with immediate consumption
    do_reset();
    grants = 3; out_ready = 1'b1;
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_req_valid", 32'(Inst_Req_Valid), 32'd0);
    check("rst_pc", PC, 32'h0);
    check("rst_fetch_cnt", fetch_cnt, 32'd0);
    check("rst_drop_cnt", drop_cnt, 32'd0);
    for (int i = 0; i < 10; i++) begin
      if (Inst_Req_Valid) break;
      @(negedge clk);
    end
    check("first_req_valid", 32'(Inst_Req_Valid), 32'd1);
    check("first_req_pc", PC, 32'h0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (sb.size() == 0 && fetch_cnt == 32'd3) break;
    end
    check("seq_drained", 32'(sb.size()), 32'd0);
    check("seq_fetch_cnt", fetch_cnt, 32'd3);
    check("seq_pc", PC, 32'hC);

    // Backpressure: credit limit of 4, then one pop frees exactly one request
    do_reset();
    grants = 100;
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8); expect_pc(32'hC);
    repeat (12) @(negedge clk);
    check("full_fetch_cnt", fetch_cnt, 32'd4);
    check("full_req_valid", 32'(Inst_Req_Valid), 32'd0);
    check("full_pc", PC, 32'h10);
    check("full_head_pc", out_pc, 32'h0);
    tick(); out_ready = 1'b1;
    tick(); out_ready = 1'b0;
    expect_pc(32'h10);
    repeat (6) @(negedge clk);
    check("refill_fetch_cnt", fetch_cnt, 32'd5);
    check("refill_pc", PC, 32'h14);
    check("refill_req_valid", 32'(Inst_Req_Valid), 32'd0);
    tick(); grants = 0; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (sb.size() == 0) break;
    end
    check("full_drained", 32'(sb.size()), 32'd0);

    // Redirect with two requests in flight
    do_reset();
    grants = 2; resp_en = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fetch_cnt == 32'd2) break;
    end
    check("redir_inflight", fetch_cnt, 32'd2);
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h100; resp_en = 1'b1; grants = 2;
    expect_pc(32'h100); expect_pc(32'h104);
    tick(); redirect_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (sb.size() == 0 && fetch_cnt == 32'd4 && drop_cnt == 32'd2) break;
    end
    check("redir_drained", 32'(sb.size()), 32'd0);
    check("redir_drop_cnt", drop_cnt, 32'd2);
    check("redir_fetch_cnt", fetch_cnt, 32'd4);
    check("redir_pc", PC, 32'h108);

    // Redirect colliding with a response and a would-be pop
    do_reset();
    grants = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("coll_buffered", 32'(out_valid), 32'd1);
    tick(); resp_en = 1'b0; grants = 2;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fetch_cnt == 32'd3) break;
    end
    tick(); resp_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (Inst_Valid) break;
    end
    check("coll_resp_present", 32'(Inst_Valid), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h40; out_ready = 1'b1; grants = 0;
    @(negedge clk);
    check("coll_out_masked", 32'(out_valid), 32'd0);
    check("coll_no_req", 32'(Inst_Req_Valid), 32'd0);
    tick(); redirect_valid = 1'b0; grants = 2;
    expect_pc(32'h40); expect_pc(32'h44);
    @(negedge clk);
    check("coll_flushed", 32'(out_valid), 32'd0);
    check("coll_drop_now", drop_cnt, 32'd1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (sb.size() == 0 && fetch_cnt == 32'd5 && drop_cnt == 32'd2) break;
    end
    check("coll_drained", 32'(sb.size()), 32'd0);
    check("coll_drop_cnt", drop_cnt, 32'd2);
    check("coll_fetch_cnt", fetch_cnt, 32'd5);

    // Misaligned redirect target
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h203; grants = 2; out_ready = 1'b1;
    expect_pc(32'h200); expect_pc(32'h204);
    tick(); redirect_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (Inst_Req_Valid) break;
    end
    check("align_req_pc", PC, 32'h200);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (sb.size() == 0 && fetch_cnt == 32'd2) break;
    end
    check("align_drained", 32'(sb.size()), 32'd0);
    check("align_drop_cnt", drop_cnt, 32'd0);

    // Reset with 3 buffered and 1 in flight, then a stray response
    do_reset();
    grants = 3;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fetch_cnt == 32'd3) break;
    end
    repeat (3) @(negedge clk);
    tick(); resp_en = 1'b0; grants = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fetch_cnt == 32'd4) break;
    end
    check("mid_fetch_cnt", fetch_cnt, 32'd4);
    check("mid_out_valid", 32'(out_valid), 32'd1);
    tick(); rst = 1'b1;
    tick();
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_pc", PC, 32'h0);
    check("mid_rst_fetch_cnt", fetch_cnt, 32'd0);
    tick(); rst = 1'b0; grants = 0; resp_en = 1'b1; inject = 1'b1;
    repeat (4) @(negedge clk);
    check("stray_out_valid", 32'(out_valid), 32'd0);
    check("stray_fetch_cnt", fetch_cnt, 32'd0);
    check("stray_drop_cnt", drop_cnt, 32'd0);
    tick(); out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
